// File: rtl/line_arb_pkg.sv
// Shared types and defaults for the two-requester line arbiter.
package line_arb_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_LINE_W     = 256;
  localparam int unsigned DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  // A simultaneous read+write request resolves to a write.
  function automatic op_t decode_op(input logic read, input logic write);
    return write ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/line_arbiter_starve_counter.sv
// Saturating counter of consecutive D grants taken while I is waiting.
module arb_starve_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/line_arbiter.sv
// Shares one line-wide memory port between I and D requesters; D has priority,
// bounded by a starvation counter that eventually forces an I grant.
module line_arbiter
  import line_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_W     = DEF_LINE_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state;
  logic              i_req;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;
  op_t               grant_op;
  logic [ADDR_W-1:0] grant_addr;
  logic [LINE_W-1:0] grant_wdata;
  logic              starve_inc;
  logic              starve_clr;
  logic              starve_at_max;
  logic [CNT_W-1:0]  starve_cnt;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  always_comb begin
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    grant_op    = OP_READ;
    grant_addr  = '0;
    grant_wdata = '0;
    if (state == IDLE) begin
      if (i_req && (!d_req || starve_at_max)) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
    if (grant_i) begin
      grant_op    = decode_op(i_read, i_write);
      grant_addr  = i_addr;
      grant_wdata = i_wdata;
    end else if (grant_d) begin
      grant_op    = decode_op(d_read, d_write);
      grant_addr  = d_addr;
      grant_wdata = d_wdata;
    end
  end

  // Counting only happens on a D grant with I waiting; any idle cycle without
  // an I request forgets past starvation.
  assign starve_inc = grant_d & i_req;
  assign starve_clr = grant_i | ((state == IDLE) & ~i_req);

  arb_starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .count  (starve_cnt),
    .at_max (starve_at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state        <= grant_i ? SERVE_I : SERVE_D;
            pmem_read    <= (grant_op == OP_READ);
            pmem_write   <= (grant_op == OP_WRITE);
            pmem_address <= grant_addr;
            pmem_wdata   <= grant_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= RELEASE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is passed through in the same cycle, gated by the owning state.
  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_line_arbiter.sv
// Scoreboard bench: directed stimulus queues expected pmem requests and responses,
// an independent negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_line_arbiter;
  import line_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0, i_write = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_wdata = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  line_arbiter #(
    .ADDR_W     (AW),
    .LINE_W     (LW),
    .STARVE_MAX (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  typedef struct {
    logic          is_write;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic          side_d;
    logic [LW-1:0] rdata;
  } resp_t;

  txn_t  exp_txn[$];
  resp_t exp_resp[$];
  int    checks = 0;
  int    errors = 0;

  function automatic txn_t mk_txn(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    txn_t t;
    t.is_write = w;
    t.addr     = a;
    t.wdata    = d;
    return t;
  endfunction

  function automatic resp_t mk_resp(input logic side_d, input logic [LW-1:0] rd);
    resp_t r;
    r.side_d = side_d;
    r.rdata  = rd;
    return r;
  endfunction

  function automatic logic [LW-1:0] pat(input logic [31:0] n);
    return {8{n}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pmem request starts, hold stability, and response routing.
  logic          prev_active = 1'b0;
  logic          cur_valid = 1'b0;
  txn_t          cur;
  always @(negedge clk) begin
    resp_t r;
    if (pmem_read || pmem_write) begin
      if (!prev_active) begin
        if (exp_txn.size() == 0) begin
          checks++;
          errors++;
          cur_valid = 1'b0;
          $display("FAIL unexpected_txn: addr %0h with no expectation", pmem_address);
        end else begin
          cur = exp_txn.pop_front();
          cur_valid = 1'b1;
          check("txn_write", pmem_write, cur.is_write);
          check("txn_read", pmem_read, !cur.is_write);
          check("txn_addr", pmem_address, cur.addr);
          check("txn_wdata", pmem_wdata, cur.wdata);
        end
      end else if (cur_valid) begin
        check("hold_addr", pmem_address, cur.addr);
        check("hold_wdata", pmem_wdata, cur.wdata);
        check("hold_write", pmem_write, cur.is_write);
      end
      check("op_exclusive", pmem_read & pmem_write, 1'b0);
    end
    prev_active = pmem_read || pmem_write;
    if (i_resp || d_resp) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: i_resp %0b d_resp %0b", i_resp, d_resp);
      end else begin
        r = exp_resp.pop_front();
        check("resp_i", i_resp, !r.side_d);
        check("resp_d", d_resp, r.side_d);
        check("resp_rdata", r.side_d ? d_rdata : i_rdata, r.rdata);
      end
    end
  end

  // Returns at the first negedge that shows an active pmem request.
  task automatic wait_active(output int idle);
    idle = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) return;
      idle++;
    end
    checks++;
    errors++;
    $display("FAIL wait_active: no pmem request within 50 cycles");
  endtask

  // Called at an active negedge; ends at posedge+1 of the RELEASE cycle.
  task automatic do_resp(input logic [LW-1:0] rd, input int delay);
    repeat (delay) @(posedge clk);
    #1;
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_i_resp", i_resp, 1'b0);
    check("rst_d_resp", d_resp, 1'b0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_state", dut.state, IDLE);
    check("rst_starve_cnt", dut.starve_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single D read with request-to-pmem latency of one cycle
    exp_txn.push_back(mk_txn(1'b0, 32'h0000_1000, '0));
    exp_resp.push_back(mk_resp(1'b1, pat(32'hDEAD_0001)));
    d_read = 1'b1;
    d_addr = 32'h0000_1000;
    @(negedge clk);
    check("lat_not_early", pmem_read, 1'b0);
    @(negedge clk);
    check("lat_n_plus_1", pmem_read, 1'b1);
    do_resp(pat(32'hDEAD_0001), 5);
    d_read = 1'b0;
    settle();

    // Simultaneous I read and D write: D first, then I after two idle cycles
    exp_txn.push_back(mk_txn(1'b1, 32'h0000_0080, {32{8'hA5}}));
    exp_txn.push_back(mk_txn(1'b0, 32'h0000_0040, '0));
    exp_resp.push_back(mk_resp(1'b1, pat(32'h0000_B0B0)));
    exp_resp.push_back(mk_resp(1'b0, pat(32'h0000_C0C0)));
    i_read  = 1'b1;
    i_addr  = 32'h0000_0040;
    d_write = 1'b1;
    d_addr  = 32'h0000_0080;
    d_wdata = {32{8'hA5}};
    wait_active(idle);
    do_resp(pat(32'h0000_B0B0), 2);
    d_write = 1'b0;
    d_wdata = '0;
    wait_active(idle);
    check("turnaround_idle", idle, 2);
    do_resp(pat(32'h0000_C0C0), 3);
    i_read = 1'b0;
    settle();

    // Starvation: four D grants, then I is forced
    for (int k = 0; k < 4; k++) begin
      exp_txn.push_back(mk_txn(1'b0, 32'h0000_0400, '0));
      exp_resp.push_back(mk_resp(1'b1, pat(32'h1000 + k)));
    end
    exp_txn.push_back(mk_txn(1'b0, 32'h0000_0300, '0));
    exp_resp.push_back(mk_resp(1'b0, pat(32'h0000_3333)));
    i_read = 1'b1;
    i_addr = 32'h0000_0300;
    d_read = 1'b1;
    d_addr = 32'h0000_0400;
    for (int k = 0; k < 4; k++) begin
      wait_active(idle);
      check("starve_cnt_d_grant", dut.starve_cnt, k + 1);
      do_resp(pat(32'h1000 + k), 1);
    end
    wait_active(idle);
    check("starve_forced_i_addr", pmem_address, 32'h0000_0300);
    check("starve_cnt_cleared", dut.starve_cnt, 0);
    do_resp(pat(32'h0000_3333), 1);
    i_read = 1'b0;
    d_read = 1'b0;
    settle();

    // Address change mid-SERVE_D is ignored; stray pmem_resp in IDLE is ignored
    exp_txn.push_back(mk_txn(1'b0, 32'h0000_1000, '0));
    exp_resp.push_back(mk_resp(1'b1, pat(32'h0000_4444)));
    d_read = 1'b1;
    d_addr = 32'h0000_1000;
    wait_active(idle);
    d_addr  = 32'h0000_2000;
    d_wdata = pat(32'h0000_0009);
    repeat (2) @(negedge clk);
    check("mid_addr_hold", pmem_address, 32'h0000_1000);
    do_resp(pat(32'h0000_4444), 1);
    d_read  = 1'b0;
    d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    pmem_resp = 1'b1;
    @(negedge clk);
    check("stray_i_resp", i_resp, 1'b0);
    check("stray_d_resp", d_resp, 1'b0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check("stray_state", dut.state, IDLE);
    check("stray_pmem_read", pmem_read, 1'b0);
    @(posedge clk);
    #1;

    // Reset during SERVE_I aborts; pending D is then granted from IDLE
    exp_txn.push_back(mk_txn(1'b0, 32'h0000_0500, '0));
    i_read = 1'b1;
    i_addr = 32'h0000_0500;
    wait_active(idle);
    d_read = 1'b1;
    d_addr = 32'h0000_0600;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_pmem_read", pmem_read, 1'b0);
    check("rst_mid_i_resp", i_resp, 1'b0);
    check("rst_mid_address", pmem_address, '0);
    i_read = 1'b0;
    exp_txn.push_back(mk_txn(1'b0, 32'h0000_0600, '0));
    exp_resp.push_back(mk_resp(1'b1, pat(32'h0000_6666)));
    @(negedge clk);
    rst_n = 1'b1;
    wait_active(idle);
    do_resp(pat(32'h0000_6666), 2);
    d_read = 1'b0;
    settle();

    // Read and write both high: write wins
    exp_txn.push_back(mk_txn(1'b1, 32'h0000_0700, pat(32'h0000_0007)));
    exp_resp.push_back(mk_resp(1'b1, pat(32'h0000_7777)));
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_0700;
    d_wdata = pat(32'h0000_0007);
    wait_active(idle);
    check("both_pmem_write", pmem_write, 1'b1);
    check("both_pmem_read", pmem_read, 1'b0);
    do_resp(pat(32'h0000_7777), 2);
    d_read  = 1'b0;
    d_write = 1'b0;
    settle();

    repeat (3) @(posedge clk);
    check("txn_queue_empty", exp_txn.size(), 0);
    check("resp_queue_empty", exp_resp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
